// File: rtl/sb_pkg.sv
// sb_pkg: shared sideband constants and serializer state encoding
package sb_pkg;
    localparam int SB_WIDTH = 128;
    localparam int SB_GAP   = 32;
    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} sb_state_t;
endpackage

// File: rtl/sb_tx_holdreg.sv
// sb_tx_holdreg: one-entry valid/ready holding register ahead of the shifter
// ports: clk, rst (async high); in_data/in_valid/in_ready upstream handshake;
//        take frees the entry; hold_data/hold_valid present the held packet
module sb_tx_holdreg #(
    parameter int WIDTH = sb_pkg::SB_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             take,
    output logic [WIDTH-1:0] hold_data,
    output logic             hold_valid
);
    assign in_ready = !hold_valid;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (in_valid && in_ready) begin
            hold_valid <= 1'b1;
            hold_data  <= in_data;
        end else if (take) begin
            hold_valid <= 1'b0;
        end
endmodule

// File: rtl/sb_serializer.sv
// sb_serializer: sideband transmit serializer, LSB-first with fixed idle gap
// ports: clk, rst (async high); in_data/in_valid/in_ready packet handshake;
//        out_data serial bit, out_clk_en forwarded-clock enable, tx_done last-bit pulse
module sb_serializer
    import sb_pkg::*;
#(
    parameter int WIDTH   = SB_WIDTH,
    parameter int WIDTH_W = 8,
    parameter int GAP     = SB_GAP,
    parameter int GAP_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_data,
    output logic             out_clk_en,
    output logic             tx_done
);
    sb_state_t          state;
    logic [WIDTH-1:0]   shift_reg, hold_data;
    logic [WIDTH_W-1:0] bit_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               hold_valid, load, last_bit, last_gap;

    assign last_bit = bit_cnt == WIDTH_W'(WIDTH - 1);
    assign last_gap = gap_cnt == GAP_W'(GAP - 1);
    // the gap-end edge loads directly so back-to-back packets skip IDLE
    assign load = hold_valid && (state == ST_IDLE || (state == ST_GAP && last_gap));

    sb_tx_holdreg #(.WIDTH(WIDTH)) u_hold (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .take(load),
        .hold_data(hold_data),
        .hold_valid(hold_valid)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
        end else if (load) begin
            state     <= ST_SEND;
            shift_reg <= hold_data;
            bit_cnt   <= '0;
        end else if (state == ST_SEND) begin
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + WIDTH_W'(1);
            if (last_bit) begin
                state   <= ST_GAP;
                gap_cnt <= '0;
            end
        end else if (state == ST_GAP) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
            if (last_gap) state <= ST_IDLE;
        end

    assign out_clk_en = state == ST_SEND;
    assign out_data   = out_clk_en && shift_reg[0];
    assign tx_done    = out_clk_en && last_bit;
endmodule

// File: tb/tb_sb_serializer.sv
// tb_sb_serializer: random-stimulus bench for an 8-bit/gap-4 and a 128-bit/gap-32 serializer
module tb_sb_serializer;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    logic [127:0] in_data [2];
    logic [1:0]   in_valid, in_ready, out_data, out_clk_en, tx_done;
    logic [1:0]   busy_m, acc_m;
    int           total = 0, bad = 0;
    longint       cyc = 0, st_prev = 0, st_last = 0;
    logic         pe0 = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int W = g ? 128 : 8;
        localparam int G = g ? 32 : 4;
        localparam logic [127:0] M = {128{1'b1}} >> (128 - W);

        sb_serializer #(.WIDTH(W), .WIDTH_W(8), .GAP(G), .GAP_W(6)) dut (
            .clk(clk),
            .rst(rst),
            .in_data(in_data[g][W-1:0]),
            .in_valid(in_valid[g]),
            .in_ready(in_ready[g]),
            .out_data(out_data[g]),
            .out_clk_en(out_clk_en[g]),
            .tx_done(tx_done[g])
        );

        logic [127:0] hw = 0, cw = 0, rx = 0;
        logic         hf = 0, cv = 0, acc_t = 0;
        longint       e = 0, cs = 0, na = 0;
        int           ridx = 0;
        logic [127:0] q[$];

        // transaction-level model: one holding slot; a held packet starts on the first
        // edge at or after the previous start + W + G
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                hf = 0;
                cv = 0;
                e  = 0;
                na = 0;
                q.delete();
            end else begin : step
                bit ld, acc;
                e++;
                ld  = hf && e >= na;
                acc = in_valid[g] && !hf;
                if (ld) begin
                    cw = hw;
                    cs = e;
                    cv = 1;
                    hf = 0;
                    na = e + W + G;
                end
                if (acc) begin
                    hw    = in_data[g] & M;
                    hf    = 1;
                    acc_t = ~acc_t;
                    q.push_back(hw);
                end
            end
        end

        always @(negedge clk) begin
            if (rst) begin
                ridx = 0;
                rx   = 0;
            end else begin : chk_blk
                longint k;
                bit snd, eb;
                k   = e - cs;
                snd = cv && k < W;
                eb  = 0;
                if (snd) eb = cw[int'(k)];
                chk($sformatf("i%0d_data", g), 128'(out_data[g]), 128'(eb));
                chk($sformatf("i%0d_clk_en", g), 128'(out_clk_en[g]), 128'(snd));
                chk($sformatf("i%0d_done", g), 128'(tx_done[g]), 128'(snd && k == W - 1));
                chk($sformatf("i%0d_ready", g), 128'(in_ready[g]), 128'(!hf));
                if (out_clk_en[g] && ridx < 128) begin
                    rx[ridx] = out_data[g];
                    ridx++;
                end
                if (tx_done[g]) begin
                    if (q.size() == 0) chk($sformatf("i%0d_unexpected_word", g), 128'(q.size()), 128'(1));
                    else chk($sformatf("i%0d_word", g), rx, q.pop_front());
                    ridx = 0;
                    rx   = 0;
                end
            end
        end

        assign busy_m[g] = hf || (e < na);
        assign acc_m[g]  = acc_t;
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (out_clk_en[0] && !pe0) begin
            st_prev = st_last;
            st_last = cyc;
        end
        pe0 = out_clk_en[0];
    end

    task automatic send(input int g, input logic [127:0] d, input bit jitter);
        logic a0;
        a0          = acc_m[g];
        in_valid[g] = 1;
        in_data[g]  = d;
        for (int i = 0; i < 1000 && acc_m[g] == a0; i++) begin
            @(negedge clk);
            if (jitter && acc_m[g] == a0) in_data[g] = {$urandom, $urandom, $urandom, $urandom};
        end
        chk("accept_timeout", 128'(acc_m[g] != a0), 128'(1));
        in_valid[g] = 0;
    endtask

    task automatic wait_idle(input int g);
        for (int i = 0; i < 2000 && busy_m[g]; i++) @(negedge clk);
        chk("idle_timeout", 128'(busy_m[g]), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        in_valid   = 0;
        in_data[0] = 0;
        in_data[1] = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        repeat (50) @(negedge clk);
        send(0, 128'hA5, 0);
        wait_idle(0);
        send(0, 128'h01, 0);
        send(0, 128'hFF, 0);
        wait_idle(0);
        chk("b2b_start_gap", 128'(st_last - st_prev), 128'(12));
        send(0, 128'($urandom), 0);
        send(0, 0, 1);
        wait_idle(0);
        repeat (100) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 200)) @(negedge clk);
            send(1, {$urandom, $urandom, $urandom, $urandom}, 0);
        end
        wait_idle(1);
        send(1, {$urandom, $urandom, $urandom, $urandom}, 0);
        send(1, {$urandom, $urandom, $urandom, $urandom}, 0);
        for (int i = 0; i < 400 && !(u[1].cv && u[1].e - u[1].cs == 60); i++) @(negedge clk);
        chk("pre_rst_clk_en", 128'(out_clk_en[1]), 128'(1));
        chk("pre_rst_ready", 128'(in_ready[1]), 128'(0));
        #2 rst = 1;
        #1;
        chk("rst_clk_en", 128'(out_clk_en[1]), 128'(0));
        chk("rst_ready", 128'(in_ready[1]), 128'(1));
        chk("rst_data", 128'(out_data[1]), 128'(0));
        @(negedge clk);
        #2 rst = 0;
        repeat (200) @(negedge clk);
        send(1, 128'h5, 0);
        wait_idle(1);
        chk("q0_drained", 128'(u[0].q.size()), 128'(0));
        chk("q1_drained", 128'(u[1].q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sb_serializer.md
# sb_serializer

Sideband transmit serializer: accepts a WIDTH-bit sideband packet over a valid/ready handshake and shifts it out LSB-first, one bit per clock, together with a clock-enable that gates the forwarded sideband clock. It is the transmit-side counterpart of the sideband deserializer. It updates on posedge so data is stable when the receiver samples on negedge. It enforces a fixed idle gap between packets. A one-entry holding register lets the next packet be accepted while the current one is still shifting.

## Interface
- WIDTH, 128, packet width in bits
- WIDTH_W, 8, width of bit counter (≥ clog2(WIDTH))
- GAP, 32, idle cycles between packets (≥1)
- GAP_W, 6, width of gap counter (≥ clog2(GAP))

- clk  in  1  sideband clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- in_data  in  WIDTH  packet to send; bit 0 transmitted first
- in_valid  in  1  in_data valid
- in_ready  out  1  holding register empty
- out_data  out  1  serial bit
- out_clk_en  out  1  forwarded-clock enable; high only while a bit is on out_data
- tx_done  out  1  one-cycle pulse on the cycle the last bit is driven

## Operation
- Holding register: hold_data/hold_valid. in_ready = !hold_valid, combinational. Accept on posedge when in_valid && in_ready; hold_valid ← 1.
- FSM states: IDLE, SEND, GAP.
  - IDLE: if hold_valid, on the next edge load shift_reg ← hold_data, clear hold_valid, bit_cnt ← 0, go to SEND.
  - SEND: each edge shifts shift_reg right by 1 and increments bit_cnt. On the edge where bit_cnt == WIDTH-1: go to GAP, gap_cnt ← 0.
  - GAP: each edge increments gap_cnt. On the edge where gap_cnt == GAP-1: go to SEND with load if hold_valid, else go to IDLE.
- Outputs (combinational from state):
  - out_data = shift_reg[0] in SEND, else 0.
  - out_clk_en = (state == SEND).
  - tx_done = SEND && bit_cnt == WIDTH-1.
- Accept and load on the same edge is impossible, because in_ready is low whenever hold_valid is set. A load frees the holding register, and in_ready is high from the following cycle.
- in_valid while in_ready is low: no effect; the source holds its data.

## Timing
- Reset values: state IDLE, hold_valid 0, bit_cnt 0, gap_cnt 0, shift_reg 0. Outputs: in_ready 1, out_data 0, out_clk_en 0, tx_done 0.
- Latency: accept at edge t → SEND entered at edge t+1. Bit i is on out_data in the cycle following edge t+1+i, for i = 0..WIDTH-1.
- Packet occupies exactly WIDTH consecutive cycles with out_clk_en high. It is followed by exactly GAP cycles with out_clk_en low and out_data 0.
- Back-to-back throughput with a packet already held: one packet every WIDTH+GAP cycles, with no extra IDLE cycle.
- Counters never wrap: bit_cnt is cleared on load, and gap_cnt is cleared on entry to GAP.
- Reset asserted mid-packet: all state clears immediately (asynchronous) and out_clk_en drops the same instant. The partial packet and the held packet are discarded, and in_ready reads 1 after reset.

## Structure
- Shared sideband package holds the state enum (IDLE/SEND/GAP), the default packet width (128), and the gap constant (32). The deserializer reuses the width constant.
- One natural sub-module, sb_tx_holdreg: the one-entry valid/ready holding register. The FSM and shifter stay in the top.

## Test plan
- WIDTH=8, GAP=4, send 0xA5 after reset:
  - out_data sequence 1,0,1,0,0,1,0,1 over 8 cycles with out_clk_en high.
  - tx_done only in the 8th cycle.
  - Then 4 cycles of out_clk_en=0, out_data=0.
  - Then IDLE.
- Back-to-back 0x01 then 0xFF, second presented while first shifts:
  - in_ready low from the accept until the first load.
  - Second packet starts exactly 12 cycles after the first starts.
- Loopback through the sideband deserializer, WIDTH=128, with random payloads ×100: received word equals the sent word every time.
- in_valid held high with in_ready low: in_data changes are ignored until in_ready rises. The word that was accepted is the one transmitted.
- rst pulsed at bit 60 of a 128-bit packet with a second packet held:
  - out_clk_en drops immediately.
  - No bits follow, and in_ready is 1.
  - A new packet 0x5 is sent correctly.
- No input for 50 cycles after reset: out_clk_en 0, out_data 0, in_ready 1 throughout.
